fetch_unit: RTL and testbench

//  Program-counter and instruction-fetch stage sitting directly upstream of instr_mem.

---
 rtl/memory_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the instruction-memory side of the core:
// the fetch queue entry, the fetch control states and the PC step helper.
package memory_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } fetch_state_e;

   // Sequential PC; wraps naturally at 32 bits (FFFF_FFFC -> 0000_0000).
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: small circular buffer of {pc, instr} entries between fetch and
// decode. Flush has priority over push/pop and empties the queue in one cycle.
// Storage is not reset; only pointers and count are.
module fetch_fifo
   import memory_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  fetch_entry_t                   wdata,
   output fetch_entry_t                   rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap modulo DEPTH, also for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Pointer and occupancy control; flush clears the queue outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wrap_inc(wr_ptr);
         if (pop)  rd_ptr <= wrap_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage. Drives the ROM address straight
// from the PC register, captures the combinational ROM word in the same cycle
// and queues {pc, instr} for decode. A redirect flushes the queue and reloads
// the PC. Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect
// halts fetch and raises the sticky misalign_o flag).
module fetch_unit
   import memory_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        arst_n_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        dec_valid_o,
   input  logic        dec_ready_i,
   output logic [31:0] dec_pc_o,
   output logic [31:0] dec_instr_o,
   output logic        misalign_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [31:0]      pc_q;
   logic [31:0]      pc_d;
   fetch_state_e     state_q;
   fetch_state_e     state_d;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     tail;
   logic [31:0]      target;
   logic             misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misaligned = |redirect_pc_i[1:0];
   assign target     = redirect_pc_i;
   assign misalign_o = (state_q == S_HALT);
`else
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^redirect_pc_i[1:0];
   assign misaligned    = 1'b0;
   assign target        = {redirect_pc_i[31:2], 2'b00};
   assign misalign_o    = 1'b0;
`endif

   assign imem_addr_o = pc_q;
   assign dec_valid_o = (count != '0);
   assign pop         = dec_valid_o & dec_ready_i;
   // A full queue still accepts a new entry when the head leaves this cycle.
   assign push        = (state_q == S_RUN) & ~redirect_valid_i & ((count < FULL_CNT) | pop);
   assign tail        = '{pc: pc_q, instr: imem_data_i};

   // Outputs read as zero while the queue is empty.
   assign dec_pc_o    = dec_valid_o ? head.pc    : 32'h0;
   assign dec_instr_o = dec_valid_o ? head.instr : 32'h0;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (arst_n_i),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid_i),
      .wdata (tail),
      .rdata (head),
      .count (count)
   );

   // Next PC and state: redirect wins, otherwise advance only on a push.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redirect_valid_i) begin
         pc_d = target;
         if (state_q == S_RUN && misaligned) state_d = S_HALT;
      end else if (push) begin
         pc_d = next_pc(pc_q);
      end
   end

   // PC and fetch state registers; halt is left only through reset.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         pc_q    <= RESET_PC;
         state_q <= S_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          DEPTH   = 2;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [31:0] imem_addr, imem_data;
   logic        rv = 1'b0;
   logic [31:0] rpc = 32'h0;
   logic        dec_valid, dec_ready = 1'b0;
   logic [31:0] dec_pc, dec_instr;
   logic        misalign;

   logic [31:0] w_addr, w_data, w_pc, w_instr;
   logic        w_valid, w_mis;
   logic        w_ready = 1'b1;
   logic        w_rv = 1'b0;
   logic [31:0] w_rpc = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // ROM contents: arbitrary but distinct per word address.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h0000_0013;
   endfunction

   assign imem_data = rom(imem_addr);
   assign w_data    = rom(w_addr);

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .arst_n_i(arst_n), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .redirect_valid_i(rv), .redirect_pc_i(rpc), .dec_valid_o(dec_valid),
      .dec_ready_i(dec_ready), .dec_pc_o(dec_pc), .dec_instr_o(dec_instr), .misalign_o(misalign));

   fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
      .clk_i(clk), .arst_n_i(arst_n), .imem_addr_o(w_addr), .imem_data_i(w_data),
      .redirect_valid_i(w_rv), .redirect_pc_i(w_rpc), .dec_valid_o(w_valid),
      .dec_ready_i(w_ready), .dec_pc_o(w_pc), .dec_instr_o(w_instr), .misalign_o(w_mis));

   // ---------------- reference model: queue of pending fetches ----------------
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_halt;

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'h0;
      m_halt = 1'b0;
   endtask

   task automatic model_step(input logic r, input logic [31:0] t, input logic rdy);
      bit   do_pop, do_push;
      ent_t e;
      if (r) begin
         mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
         if (t[1:0] != 2'b00) m_halt = 1'b1;
         m_pc = t;
`else
         m_pc = {t[31:2], 2'b00};
`endif
      end else begin
         do_pop  = (mq.size() > 0) && rdy;
         do_push = !m_halt && ((mq.size() < DEPTH) || do_pop);
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e.pc = m_pc;
            e.instr = rom(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   function automatic logic exp_valid();
      return mq.size() != 0;
   endfunction
   function automatic logic [31:0] exp_pc();
      return (mq.size() != 0) ? mq[0].pc : 32'h0;
   endfunction
   function automatic logic [31:0] exp_instr();
      return (mq.size() != 0) ? mq[0].instr : 32'h0;
   endfunction

   // One clock: apply inputs, let the edge happen, advance the model, settle.
   task automatic drive_cycle(input logic r, input logic [31:0] t, input logic rdy);
      rv = r;
      rpc = t;
      dec_ready = rdy;
      @(posedge clk);
      model_step(r, t, rdy);
      @(negedge clk);
      #1;
   endtask

   task automatic reset_dut();
      arst_n = 1'b0;
      rv = 1'b0;
      dec_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      model_reset();
      arst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      arst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
      n_tests++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", dec_pc); end
      n_tests++; if (dec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", dec_instr); end
      n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
      n_tests++; if (w_addr !== WRAP_PC) begin n_fail++; $display("FAIL reset_waddr got=%h exp=%h", w_addr, WRAP_PC); end
      model_reset();
      arst_n = 1'b1;
   endtask

   task automatic test_stream();
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_tests++; if (dec_valid !== exp_valid()) begin n_fail++; $display("FAIL stream_valid c=%0d got=%b exp=%b", i, dec_valid, exp_valid()); end
         n_tests++; if (dec_pc !== exp_pc()) begin n_fail++; $display("FAIL stream_pc c=%0d got=%h exp=%h", i, dec_pc, exp_pc()); end
         n_tests++; if (dec_instr !== exp_instr()) begin n_fail++; $display("FAIL stream_instr c=%0d got=%h exp=%h", i, dec_instr, exp_instr()); end
         n_tests++; if (dec_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_seq c=%0d got=%h exp=%h", i, dec_pc, 32'(4 * i)); end
         n_tests++; if (dec_instr !== rom(32'(4 * i))) begin n_fail++; $display("FAIL stream_rom c=%0d got=%h exp=%h", i, dec_instr, rom(32'(4 * i))); end
      end
   endtask

   task automatic test_backpressure();
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b0);
         n_tests++; if (dec_pc !== exp_pc()) begin n_fail++; $display("FAIL bp_hold_pc c=%0d got=%h exp=%h", i, dec_pc, exp_pc()); end
         n_tests++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL bp_hold_addr c=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      end
      n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_addr_held got=%h exp=8", imem_addr); end
      n_tests++; if (dec_pc !== 32'h0 || dec_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head got=%h/%b exp=0/1", dec_pc, dec_valid); end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_tests++; if (dec_pc !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL bp_release c=%0d got=%h exp=%h", i, dec_pc, 32'(4 * (i + 1))); end
         n_tests++; if (dec_instr !== exp_instr()) begin n_fail++; $display("FAIL bp_instr c=%0d got=%h exp=%h", i, dec_instr, exp_instr()); end
      end
   endtask

   task automatic test_redirect_full();
      reset_dut();
      repeat (3) drive_cycle(1'b0, 32'h0, 1'b0);
      drive_cycle(1'b1, 32'h40, 1'b1);
      n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", dec_valid); end
      n_tests++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
      drive_cycle(1'b0, 32'h0, 1'b1);
      n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40) begin n_fail++; $display("FAIL redir_first got=%b/%h exp=1/40", dec_valid, dec_pc); end
      n_tests++; if (dec_instr !== rom(32'h40)) begin n_fail++; $display("FAIL redir_instr got=%h exp=%h", dec_instr, rom(32'h40)); end
      drive_cycle(1'b1, 32'h80, 1'b1);
      drive_cycle(1'b1, 32'hC0, 1'b1);
      drive_cycle(1'b0, 32'h0, 1'b1);
      n_tests++; if (dec_pc !== 32'hC0) begin n_fail++; $display("FAIL redir_b2b got=%h exp=c0", dec_pc); end
   endtask

   task automatic test_misalign();
      reset_dut();
      repeat (2) drive_cycle(1'b0, 32'h0, 1'b1);
      drive_cycle(1'b1, 32'h42, 1'b1);
      drive_cycle(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
      n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%b exp=1", misalign); end
      n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halt got=%b exp=0", dec_valid); end
`else
      n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_flag got=%b exp=0", misalign); end
      n_tests++; if (dec_pc !== 32'h40) begin n_fail++; $display("FAIL mis_resume got=%h exp=40", dec_pc); end
`endif
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_tests++; if (dec_valid !== exp_valid() || dec_pc !== exp_pc()) begin n_fail++; $display("FAIL mis_run c=%0d got=%b/%h exp=%b/%h", i, dec_valid, dec_pc, exp_valid(), exp_pc()); end
         n_tests++; if (misalign !== m_halt) begin n_fail++; $display("FAIL mis_sticky c=%0d got=%b exp=%b", i, misalign, m_halt); end
      end
   endtask

   task automatic test_random();
      logic        r, rdy;
      logic [31:0] t;
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 15) == 0);
         t   = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
         t[1:0] = 2'b00;
`endif
         rdy = ($urandom_range(0, 3) != 0);
         drive_cycle(r, t, rdy);
         n_tests++; if (dec_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", i, dec_valid, exp_valid()); end
         n_tests++; if (dec_pc !== exp_pc()) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", i, dec_pc, exp_pc()); end
         n_tests++; if (dec_instr !== exp_instr()) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", i, dec_instr, exp_instr()); end
         n_tests++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", i, imem_addr, m_pc); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] wexp [3];
      wexp[0] = 32'hFFFF_FFF8;
      wexp[1] = 32'hFFFF_FFFC;
      wexp[2] = 32'h0000_0000;
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_tests++; if (w_valid !== 1'b1 || w_pc !== wexp[i]) begin n_fail++; $display("FAIL wrap_pc c=%0d got=%b/%h exp=1/%h", i, w_valid, w_pc, wexp[i]); end
         n_tests++; if (w_instr !== rom(wexp[i])) begin n_fail++; $display("FAIL wrap_instr c=%0d got=%h exp=%h", i, w_instr, rom(wexp[i])); end
      end
      n_tests++; if (w_addr !== 32'h4 || w_mis !== 1'b0) begin n_fail++; $display("FAIL wrap_addr got=%h/%b exp=4/0", w_addr, w_mis); end
   endtask

   task automatic test_async_reset();
      reset_dut();
      repeat (4) drive_cycle(1'b0, 32'h0, 1'b0);
      n_tests++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre got=%b exp=1", dec_valid); end
      #2;
      arst_n = 1'b0;
      #1;
      n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", dec_valid); end
      n_tests++; if (dec_pc !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_state got=%h/%h exp=0/0", dec_pc, imem_addr); end
      model_reset();
      @(negedge clk);
      #1;
      arst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_tests++; if (dec_pc !== 32'(4 * i) || dec_pc !== exp_pc()) begin n_fail++; $display("FAIL ar_restart c=%0d got=%h exp=%h", i, dec_pc, 32'(4 * i)); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_misalign();
      test_random();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
